mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals of mem_port_arbiter.
//   slave  : arbiter view (takes requests and read data, drives readys,
//            responses and the memory address/data/mask).
//   master : environment view (pipeline stages plus the byte memory).
// Fetch side : if_req_valid/if_req_ready/if_addr, if_rsp_valid/if_rsp_data.
// Data side  : d_req_valid/d_req_ready/d_addr/d_we/d_size/d_unsigned/d_wdata,
//              d_rsp_valid/d_rsp_data/d_rsp_err.
// Memory side: mem_addr/mem_write_data/mem_write_mask out, mem_read_data in.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 32
) ();
   logic                  if_req_valid;
   logic                  if_req_ready;
   logic [ADDR_WIDTH-1:0] if_addr;
   logic                  if_rsp_valid;
   logic [31:0]           if_rsp_data;

   logic                  d_req_valid;
   logic                  d_req_ready;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic                  d_we;
   logic [1:0]            d_size;
   logic                  d_unsigned;
   logic [31:0]           d_wdata;
   logic                  d_rsp_valid;
   logic [31:0]           d_rsp_data;
   logic                  d_rsp_err;

   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_write_data;
   logic [3:0]            mem_write_mask;
   logic [31:0]           mem_read_data;

   modport slave (
      input  if_req_valid, if_addr,
      output if_req_ready, if_rsp_valid, if_rsp_data,
      input  d_req_valid, d_addr, d_we, d_size, d_unsigned, d_wdata,
      output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
      output mem_addr, mem_write_data, mem_write_mask,
      input  mem_read_data
   );

   modport master (
      output if_req_valid, if_addr,
      input  if_req_ready, if_rsp_valid, if_rsp_data,
      output d_req_valid, d_addr, d_we, d_size, d_unsigned, d_wdata,
      input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
      input  mem_addr, mem_write_data, mem_write_mask,
      output mem_read_data
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and load/store.
// Data requests have default priority; a fetch denied MAX_WAIT consecutive
// cycles is forced through. Generates sb/sh/sw byte masks, extends load data
// and returns registered responses one cycle after the grant.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : mem_port_arbiter_if.slave (fetch, data and memory-side signals)
module mem_port_arbiter #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned MEM_BYTES  = 16,
   parameter int unsigned MAX_WAIT   = 4
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);
   localparam int unsigned          CntW   = $clog2(MAX_WAIT + 1);
   localparam logic [CntW-1:0]      CntMax = CntW'(MAX_WAIT);
   localparam logic [ADDR_WIDTH:0]  MemEnd = (ADDR_WIDTH + 1)'(MEM_BYTES);

   logic [CntW-1:0]     r_wait_cnt;
   logic                r_if_rsp_valid;
   logic [31:0]         r_if_rsp_data;
   logic                r_d_rsp_valid;
   logic                r_d_rsp_err;
   logic [31:0]         r_d_rsp_data;

   logic                w_force;
   logic                w_if_gnt;
   logic                w_d_gnt;
   logic [2:0]          w_nbytes;
   logic                w_d_illegal;
   logic                w_d_oob;
   logic                w_d_err;
   logic                w_if_oob;
   logic [ADDR_WIDTH:0] w_d_end;
   logic [ADDR_WIDTH:0] w_if_end;
   logic [3:0]          w_store_mask;
   logic [31:0]         w_load_data;
   logic                w_sext;

   // Arbitration; reset blocks both grants so nothing is accepted or written.
   always_comb begin
      w_force  = bus.if_req_valid && (r_wait_cnt == CntMax);
      w_d_gnt  = !reset && bus.d_req_valid && !w_force;
      w_if_gnt = !reset && bus.if_req_valid && (!bus.d_req_valid || w_force);
   end

   // Size decode, store mask and load extraction from the raw read word.
   always_comb begin
      w_sext       = !bus.d_unsigned;
      w_d_illegal  = 1'b0;
      w_nbytes     = 3'd4;
      w_store_mask = 4'b1111;
      w_load_data  = bus.mem_read_data;
      case (bus.d_size)
         2'b00: begin
            w_nbytes     = 3'd1;
            w_store_mask = 4'b0001;
            w_load_data  = {{24{w_sext & bus.mem_read_data[7]}}, bus.mem_read_data[7:0]};
         end
         2'b01: begin
            w_nbytes     = 3'd2;
            w_store_mask = 4'b0011;
            w_load_data  = {{16{w_sext & bus.mem_read_data[15]}}, bus.mem_read_data[15:0]};
         end
         2'b10: begin
            w_nbytes     = 3'd4;
            w_store_mask = 4'b1111;
            w_load_data  = bus.mem_read_data;
         end
         default: begin
            w_d_illegal  = 1'b1;
            w_store_mask = 4'b0000;
            w_load_data  = '0;
         end
      endcase
   end

   // Bounds checks use one extra bit so address + size cannot wrap.
   always_comb begin
      w_d_end  = {1'b0, bus.d_addr} + (ADDR_WIDTH + 1)'(w_nbytes);
      w_if_end = {1'b0, bus.if_addr} + (ADDR_WIDTH + 1)'(4);
      w_d_oob  = w_d_end > MemEnd;
      w_if_oob = w_if_end > MemEnd;
      w_d_err  = w_d_illegal || w_d_oob;
   end

   // Memory drive.
   always_comb begin
      bus.mem_addr       = '0;
      bus.mem_write_data = '0;
      bus.mem_write_mask = 4'b0000;
      if (w_d_gnt) begin
         bus.mem_addr       = bus.d_addr;
         bus.mem_write_data = bus.d_wdata;
         if (bus.d_we && !w_d_err) begin
            bus.mem_write_mask = w_store_mask;
         end
      end else if (w_if_gnt) begin
         bus.mem_addr = bus.if_addr;
      end
   end

   // Starvation counter: consecutive cycles a valid fetch has been denied.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wait_cnt <= '0;
      end else if (!bus.if_req_valid || w_if_gnt) begin
         r_wait_cnt <= '0;
      end else if (r_wait_cnt != CntMax) begin
         r_wait_cnt <= r_wait_cnt + CntW'(1);
      end
   end

   // Responses capture the pre-write read data at the grant edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_if_rsp_valid <= 1'b0;
         r_if_rsp_data  <= '0;
         r_d_rsp_valid  <= 1'b0;
         r_d_rsp_err    <= 1'b0;
         r_d_rsp_data   <= '0;
      end else begin
         r_if_rsp_valid <= w_if_gnt;
         r_if_rsp_data  <= (w_if_gnt && !w_if_oob) ? bus.mem_read_data : '0;
         r_d_rsp_valid  <= w_d_gnt;
         r_d_rsp_err    <= w_d_gnt && w_d_err;
         r_d_rsp_data   <= (w_d_gnt && !bus.d_we && !w_d_err) ? w_load_data : '0;
      end
   end

   // Outputs are masked while reset is high so a pending pulse is dropped.
   always_comb begin
      bus.if_req_ready = w_if_gnt;
      bus.d_req_ready  = w_d_gnt;
      bus.if_rsp_valid = r_if_rsp_valid && !reset;
      bus.if_rsp_data  = reset ? '0 : r_if_rsp_data;
      bus.d_rsp_valid  = r_d_rsp_valid && !reset;
      bus.d_rsp_err    = r_d_rsp_err && !reset;
      bus.d_rsp_data   = reset ? '0 : r_d_rsp_data;
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, all compared against a byte-array reference model.
module tb_mem_port_arbiter;
   localparam int unsigned AW = 32;
   localparam int unsigned MB = 16;
   localparam int unsigned MW = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;

   mem_port_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

   mem_port_arbiter #(
      .ADDR_WIDTH (AW),
      .MEM_BYTES  (MB),
      .MAX_WAIT   (MW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Environment memory: combinational read, posedge masked write.
   logic [7:0]  env_mem [MB];
   logic [31:0] env_rd;
   always_comb begin
      env_rd = '0;
      for (int i = 0; i < 4; i++) begin
         if ({32'b0, bus.mem_addr} + 64'(i) < 64'(MB)) begin
            env_rd[8*i +: 8] = env_mem[bus.mem_addr[3:0] + 4'(i)];
         end
      end
   end
   assign bus.mem_read_data = env_rd;

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (bus.mem_write_mask[i] && ({32'b0, bus.mem_addr} + 64'(i) < 64'(MB))) begin
            env_mem[bus.mem_addr[3:0] + 4'(i)] <= bus.mem_write_data[8*i +: 8];
         end
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model state.
   logic [7:0]  ref_mem [MB];
   int          m_wait;
   bit          pif_v, pd_v, pd_e;
   logic [31:0] pif_d, pd_d;

   // Values sampled at the last negedge, for directed checks.
   logic        s_if_rdy, s_d_rdy, s_d_rsp_v, s_d_rsp_e;
   logic [31:0] s_d_rsp_d;
   logic [3:0]  s_mask;

   function automatic bit out_of_bounds(input logic [31:0] a, input int n);
      return ({32'b0, a} + 64'(n)) > 64'(MB);
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      logic [31:0] w = '0;
      for (int i = 0; i < 4; i++) begin
         if ({32'b0, a} + 64'(i) < 64'(MB)) w[8*i +: 8] = ref_mem[int'(a) + i];
      end
      return w;
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] w, input int n, input bit uns);
      logic [31:0] v = w;
      if (n == 1) begin
         v = w & 32'hFF;
         if (!uns && w[7]) v = v | 32'hFFFF_FF00;
      end else if (n == 2) begin
         v = w & 32'hFFFF;
         if (!uns && w[15]) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   task automatic scoreboard();
      bit          frc, g_d, g_if, err;
      int          n;
      logic [3:0]  exp_mask;
      s_if_rdy  = bus.if_req_ready;
      s_d_rdy   = bus.d_req_ready;
      s_d_rsp_v = bus.d_rsp_valid;
      s_d_rsp_e = bus.d_rsp_err;
      s_d_rsp_d = bus.d_rsp_data;
      s_mask    = bus.mem_write_mask;
      if (reset) begin
         check_eq("rst_if_ready", bus.if_req_ready, 0);
         check_eq("rst_d_ready", bus.d_req_ready, 0);
         check_eq("rst_mask", bus.mem_write_mask, 0);
         check_eq("rst_if_rsp_valid", bus.if_rsp_valid, 0);
         check_eq("rst_if_rsp_data", bus.if_rsp_data, 0);
         check_eq("rst_d_rsp_valid", bus.d_rsp_valid, 0);
         check_eq("rst_d_rsp_err", bus.d_rsp_err, 0);
         check_eq("rst_d_rsp_data", bus.d_rsp_data, 0);
         m_wait = 0;
         pif_v  = 0;
         pd_v   = 0;
         return;
      end
      check_eq("if_rsp_valid", bus.if_rsp_valid, pif_v);
      if (pif_v) check_eq("if_rsp_data", bus.if_rsp_data, pif_d);
      check_eq("d_rsp_valid", bus.d_rsp_valid, pd_v);
      if (pd_v) begin
         check_eq("d_rsp_err", bus.d_rsp_err, pd_e);
         check_eq("d_rsp_data", bus.d_rsp_data, pd_d);
      end
      frc  = bus.if_req_valid && (m_wait == MW);
      g_d  = bus.d_req_valid && !frc;
      g_if = bus.if_req_valid && (!bus.d_req_valid || frc);
      check_eq("if_ready", bus.if_req_ready, g_if);
      check_eq("d_ready", bus.d_req_ready, g_d);
      pif_v    = g_if;
      pif_d    = '0;
      pd_v     = g_d;
      pd_e     = 0;
      pd_d     = '0;
      exp_mask = 4'b0000;
      if (g_if) begin
         check_eq("mem_addr_if", bus.mem_addr, bus.if_addr);
         pif_d = out_of_bounds(bus.if_addr, 4) ? 32'h0 : ref_word(bus.if_addr);
      end
      if (g_d) begin
         n   = (bus.d_size == 2'd0) ? 1 : (bus.d_size == 2'd1) ? 2 : 4;
         err = (bus.d_size == 2'd3) || out_of_bounds(bus.d_addr, n);
         check_eq("mem_addr_d", bus.mem_addr, bus.d_addr);
         check_eq("mem_wdata_d", bus.mem_write_data, bus.d_wdata);
         pd_e = err;
         if (!err) begin
            if (bus.d_we) begin
               exp_mask = 4'((1 << n) - 1);
               for (int i = 0; i < n; i++) ref_mem[int'(bus.d_addr) + i] = bus.d_wdata[8*i +: 8];
            end else begin
               pd_d = extend(ref_word(bus.d_addr), n, bus.d_unsigned);
            end
         end
      end
      if (!g_if && !g_d) begin
         check_eq("mem_addr_idle", bus.mem_addr, 0);
         check_eq("mem_wdata_idle", bus.mem_write_data, 0);
      end
      check_eq("mem_mask", bus.mem_write_mask, exp_mask);
      if (g_if || !bus.if_req_valid) m_wait = 0;
      else if (m_wait < MW) m_wait++;
   endtask

   task automatic cycle();
      @(negedge clk);
      scoreboard();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      bus.if_req_valid = 1'b0;
      bus.if_addr      = '0;
      bus.d_req_valid  = 1'b0;
      bus.d_addr       = '0;
      bus.d_we         = 1'b0;
      bus.d_size       = 2'd0;
      bus.d_unsigned   = 1'b0;
      bus.d_wdata      = '0;
   endtask

   task automatic set_d(input bit we, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      bus.d_req_valid = 1'b1;
      bus.d_we        = we;
      bus.d_size      = size;
      bus.d_unsigned  = uns;
      bus.d_addr      = addr;
      bus.d_wdata     = wdata;
   endtask

   task automatic rand_d();
      int sz = $urandom_range(0, 7);
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                      : 32'($urandom_range(0, MB + 2));
      set_d($urandom_range(0, 1) == 1, (sz == 7) ? 2'd3 : 2'(sz % 3),
            $urandom_range(0, 1) == 1, a, $urandom);
   endtask

   initial begin
      for (int i = 0; i < MB; i++) begin
         env_mem[i] = 8'($urandom);
         ref_mem[i] = env_mem[i];
      end
      m_wait = 0;
      pif_v  = 0;
      pd_v   = 0;
      set_idle();
      reset = 1'b1;
      // Reset with requests pending: both readys must stay low.
      bus.if_req_valid = 1'b1;
      set_d(1, 2'd2, 0, 0, 32'hFFFF_FFFF);
      repeat (3) cycle();
      set_idle();
      repeat (2) cycle();
      reset = 1'b0;
      repeat (2) cycle();

      // sb / lb / lbu at 5.
      set_d(1, 2'd0, 0, 5, 32'h0000_00A5);
      cycle();
      check_eq("sb_mask", s_mask, 4'b0001);
      set_d(0, 2'd0, 0, 5, 0);
      cycle();
      check_eq("sb_ack_valid", s_d_rsp_v, 1);
      check_eq("sb_ack_data", s_d_rsp_d, 0);
      set_d(0, 2'd0, 1, 5, 0);
      cycle();
      check_eq("lb_data", s_d_rsp_d, 32'hFFFF_FFA5);
      set_idle();
      cycle();
      check_eq("lbu_data", s_d_rsp_d, 32'h0000_00A5);

      // sw at 4, then lh/lhu at 6.
      set_d(1, 2'd2, 0, 4, 32'h8001_2345);
      cycle();
      check_eq("sw_mask", s_mask, 4'b1111);
      set_d(0, 2'd1, 0, 6, 0);
      cycle();
      set_d(0, 2'd1, 1, 6, 0);
      cycle();
      check_eq("lh_data", s_d_rsp_d, 32'hFFFF_8001);
      set_idle();
      cycle();
      check_eq("lhu_data", s_d_rsp_d, 32'h0000_8001);

      // Contention: data wins four times, then the fetch is forced.
      set_d(0, 2'd2, 0, 0, 0);
      bus.if_req_valid = 1'b1;
      bus.if_addr      = 32'd8;
      for (int i = 0; i < 10; i++) begin
         cycle();
         check_eq($sformatf("starve_if_rdy_%0d", i), s_if_rdy, (i == 4) || (i == 9));
         check_eq($sformatf("starve_d_rdy_%0d", i), s_d_rdy, !((i == 4) || (i == 9)));
      end
      set_idle();
      cycle();

      // Out-of-bounds word and illegal size leave memory untouched.
      set_d(1, 2'd2, 0, MB - 4, 32'h1122_3344);
      cycle();
      set_d(1, 2'd2, 0, MB - 3, 32'hDEAD_BEEF);
      cycle();
      check_eq("oob_mask", s_mask, 4'b0000);
      set_d(1, 2'd3, 0, MB - 4, 32'hFFFF_FFFF);
      cycle();
      check_eq("oob_err", s_d_rsp_e, 1);
      check_eq("illegal_mask", s_mask, 4'b0000);
      set_d(0, 2'd2, 0, MB - 4, 0);
      cycle();
      check_eq("illegal_err", s_d_rsp_e, 1);
      check_eq("illegal_data", s_d_rsp_d, 0);
      set_idle();
      cycle();
      check_eq("last_word_err", s_d_rsp_e, 0);
      check_eq("last_word_data", s_d_rsp_d, 32'h1122_3344);

      // Reset right after a granted lw drops its response.
      set_d(0, 2'd2, 0, 0, 0);
      bus.if_req_valid = 1'b1;
      repeat (2) cycle();
      reset = 1'b1;
      repeat (5) cycle();
      check_eq("rst_drop_d_valid", s_d_rsp_v, 0);
      reset = 1'b0;
      cycle();
      check_eq("post_rst_d_first", s_d_rdy, 1);
      bus.d_req_valid = 1'b0;
      cycle();
      check_eq("post_rst_if_gnt", s_if_rdy, 1);
      set_idle();
      cycle();

      // Randomized traffic honouring the hold-until-ready rule.
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 99) == 0);
         if (!bus.d_req_valid || s_d_rdy) begin
            if ($urandom_range(0, 3) != 0) rand_d();
            else bus.d_req_valid = 1'b0;
         end
         if (!bus.if_req_valid || s_if_rdy) begin
            bus.if_req_valid = ($urandom_range(0, 2) != 0);
            bus.if_addr = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFD
                                                      : 32'($urandom_range(0, MB));
         end
         cycle();
      end
      reset = 1'b0;
      set_idle();
      repeat (2) cycle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
